// File: rtl/wordle_pkg.sv
// Shared types, constants and the switch-pattern decoder for the wordle front end.
package wordle_pkg;

  typedef logic [4:0] letter_t;

  localparam logic [2:0] GRP_AG = 3'b000;
  localparam logic [2:0] GRP_HN = 3'b001;
  localparam logic [2:0] GRP_OU = 3'b010;
  localparam logic [2:0] GRP_VZ = 3'b100;

  localparam letter_t LETTER_Z = 5'd25;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COMMIT,
    ST_HELD
  } cond_state_t;

  typedef struct packed {
    logic    legal;
    letter_t code;
  } decode_t;

  // Slot is the one-hot position in [9:3] counted from bit 9; group picks a 7-letter base.
  function automatic decode_t decode_letter(input logic [9:0] sw);
    decode_t  d;
    letter_t  base;
    logic [2:0] slot;
    int       ones;
    logic     grp_ok;
    ones   = 0;
    slot   = '0;
    base   = '0;
    grp_ok = 1'b1;
    for (int i = 0; i < 7; i++) begin
      if (sw[9-i]) begin
        ones++;
        slot = 3'(i);
      end
    end
    case (sw[2:0])
      GRP_AG:  base = 5'd0;
      GRP_HN:  base = 5'd7;
      GRP_OU:  base = 5'd14;
      GRP_VZ:  base = 5'd21;
      default: grp_ok = 1'b0;
    endcase
    d.code  = base + {2'b00, slot};
    d.legal = grp_ok && (ones == 1) && ((sw[2:0] != GRP_VZ) || (slot <= 3'd4))
              && (d.code <= LETTER_Z);
    return d;
  endfunction

endpackage

// File: rtl/wordle_debounce.sv
// Two-flop synchroniser and stability counter for the active-low enter key.
module wordle_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key,
  output logic level,
  output logic fall,
  output logic rise,
  output logic pending
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             key_meta;
  logic             key_sync;
  logic [CNT_W-1:0] count;
  logic             flip;

  // The event pulses fire in the cycle whose sample completes the stable run,
  // so the level register and the consumer see the change on the same edge.
  assign pending = (key_sync != level);
  assign flip    = pending && (count == CNT_LAST);
  assign fall    = flip && level;
  assign rise    = flip && !level;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_meta <= 1'b1;
      key_sync <= 1'b1;
      level    <= 1'b1;
      count    <= '0;
    end else begin
      key_meta <= key;
      key_sync <= key_meta;
      if (!pending) begin
        count <= '0;
      end else if (count == CNT_LAST) begin
        level <= key_sync;
        count <= '0;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/wordle_input_conditioner.sv
// Debounced, validated one-cycle letter commit for the wordle game FSM.
// Optional macro WORDLE_SW_STABLE_EN rejects presses whose switches move during debounce.
module wordle_input_conditioner
  import wordle_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] switch_input,
  input  logic       enter,
  output logic       letter_valid,
  output logic [4:0] letter_code,
  output logic [9:0] letter_word,
  output logic       invalid_pulse
);

  logic [9:0]  sw_meta;
  logic [9:0]  sw_sync;
  logic        level;
  logic        fall;
  logic        rise;
  logic        pending;
  logic        sw_moved;
  logic        unused_bits;
  decode_t     dec;
  cond_state_t state;

  wordle_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk    (clk),
    .rst_n  (rst_n),
    .key    (enter),
    .level  (level),
    .fall   (fall),
    .rise   (rise),
    .pending(pending)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= switch_input;
      sw_sync <= sw_meta;
    end
  end

  assign dec = decode_letter(sw_sync);

`ifdef WORDLE_SW_STABLE_EN
  logic [9:0] sw_snap;
  logic       sw_dirty;

  // Snapshot follows the switches while the key is settled; once a press is
  // pending any difference latches dirty until the press is resolved.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_snap  <= '0;
      sw_dirty <= 1'b0;
    end else if (!pending && (state != ST_COMMIT)) begin
      sw_snap  <= sw_sync;
      sw_dirty <= 1'b0;
    end else if (sw_sync != sw_snap) begin
      sw_dirty <= 1'b1;
    end
  end

  assign sw_moved    = sw_dirty || (sw_sync != sw_snap);
  assign unused_bits = level;
`else
  assign sw_moved    = 1'b0;
  assign unused_bits = level ^ pending;
`endif

  // Reset lands in HELD so a key held through reset must be released first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_HELD;
      letter_valid  <= 1'b0;
      invalid_pulse <= 1'b0;
      letter_code   <= '0;
      letter_word   <= '0;
    end else begin
      letter_valid  <= 1'b0;
      invalid_pulse <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (fall) state <= ST_COMMIT;
        end
        ST_COMMIT: begin
          letter_word <= sw_sync;
          if (dec.legal && !sw_moved) begin
            letter_valid <= 1'b1;
            letter_code  <= dec.code;
          end else begin
            invalid_pulse <= 1'b1;
          end
          state <= ST_HELD;
        end
        ST_HELD: begin
          if (rise) state <= ST_IDLE;
        end
        default: state <= ST_HELD;
      endcase
    end
  end

endmodule

// File: doc/wordle_input_conditioner.md
# wordle_input_conditioner

Front-end stage that sits directly upstream of the wordle game FSM: it turns the raw active-low `enter` key and the 10-bit `switch_input` letter bus into a clean, debounced, one-cycle letter commit. It synchronises both inputs, debounces the key, and decodes and validates the switch pattern into a 0–25 letter index. It emits exactly one `letter_valid` or `invalid_pulse` per physical press, so the game FSM never sees bounce, repeats or illegal letter codes.

## Interface
- `DEBOUNCE_CYCLES`, 500000, number of consecutive stable synchronised samples required to accept a key level change (10 ms at 50 MHz); legal range ≥ 2.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  reset; one clock, asynchronous assert, active-low.
- `switch_input`  in  10  raw letter switches. Bits [9:3] are a one-hot slot (bit 9 = slot 0). Bits [2:0] are the group: 000 = A–G, 001 = H–N, 010 = O–U, 100 = V–Z.
- `enter`  in  1  raw push-button, active-low (0 = pressed), asynchronous, bouncy.
- `letter_valid`  out  1  one-cycle strobe: a legal letter is committed.
- `letter_code`  out  5  committed letter index, A = 0 … Z = 25; held until the next commit.
- `letter_word`  out  10  synchronised switch pattern captured at the commit; held until the next commit or invalid press.
- `invalid_pulse`  out  1  one-cycle strobe: a press was accepted but the pattern was illegal.

## Operation
- Synchronisers: two flops on `enter` (reset value 1) and two flops on each `switch_input` bit (reset value 0).
- Debounce: the counter restarts on every change of the synchronised key level. The debounced level flips only after `DEBOUNCE_CYCLES` equal consecutive samples.
- FSM states:
  - IDLE: debounced level is high (released). On debounced high→low, go to COMMIT.
  - COMMIT: one cycle. Decode the synchronised switches, assert exactly one of `letter_valid` or `invalid_pulse`, then go to HELD.
  - HELD: wait for debounced low→high, then go to IDLE.
- Reset state is HELD (arm-on-release). A key held through reset never commits until it is released and pressed again.
- Decode: legal means exactly one bit of [9:3] is set AND [2:0] ∈ {000, 001, 010, 100} AND, for group 100, slot ≤ 4.
  - Group index g = 0, 1, 2, 3 for 000, 001, 010, 100.
  - `letter_code` = 7·g + slot, computed in 5 bits; the maximum value is 25, so it never overflows.
- On a legal press, update `letter_code` and `letter_word`. On an illegal press, update `letter_word` only; `letter_code` keeps its last legal value.
- Reset values: `letter_valid` = 0, `invalid_pulse` = 0, `letter_code` = 0, `letter_word` = 0, debounce counter = 0, debounced level = 1.
- A reset asserted mid-debounce or in COMMIT aborts silently; no strobe is emitted.

## Timing
- Clean press (raw `enter` low from rising edge N, no bounce): the strobe is high for exactly the cycle after edge N + `DEBOUNCE_CYCLES` + 2. This is 2 synchroniser cycles, plus `DEBOUNCE_CYCLES`, plus 1 COMMIT register cycle.
- Switches are sampled from the synchroniser outputs in the COMMIT cycle. They must be stable for at least 3 cycles before it.
- Bounce during the press window restarts the latency from the last transition.
- Minimum spacing between two strobes is 2·`DEBOUNCE_CYCLES` + 1 cycles.
- `letter_valid` and `invalid_pulse` are never high together, and never high for two consecutive cycles.

## Configuration
- `WORDLE_SW_STABLE_EN` defined:
  - the synchronised `switch_input` must be unchanged throughout the press debounce window;
  - any change inside that window forces `invalid_pulse` at COMMIT, regardless of the final pattern;
  - this adds a 10-bit snapshot register and a compare.
- Not defined: the switches are sampled only in the COMMIT cycle; changes inside the window are ignored.

## Structure
- Shared package `wordle_pkg`:
  - `letter_t` (5-bit letter index);
  - group code constants `GRP_AG`, `GRP_HN`, `GRP_OU`, `GRP_VZ`;
  - `LETTER_Z` = 25;
  - the input-conditioner FSM state enum.
- Sub-module `wordle_debounce`: 2-flop synchroniser plus counter. It is parameterised by `DEBOUNCE_CYCLES` and outputs the debounced level and one-cycle fall/rise event pulses. The counter width is $clog2(`DEBOUNCE_CYCLES`+1).

## Test plan
All scenarios use `DEBOUNCE_CYCLES` = 4.
- Switches 10'b0100000001 (I), clean press → one `letter_valid` pulse 7 cycles after the sampled fall; `letter_code` = 8, `letter_word` = 10'h101, `invalid_pulse` stays 0.
- Switches 10'b0000100100 (Z), bouncy press (low 2, high 1, low steady) → exactly one `letter_valid` with `letter_code` = 25, timed from the final fall.
- Switches 10'b0000010100 (group VZ, slot 5) and 10'b1100000000 (two slots) → `invalid_pulse` on each press; `letter_code` unchanged.
- Key held 100 cycles → exactly one strobe; release, then press again with 10'b1000000010 (O) → second strobe with `letter_code` = 14.
- `rst_n` pulsed low mid-debounce with the key held, then released while still held → no strobe; release then re-press → normal commit. All outputs are 0 during reset.
- With `WORDLE_SW_STABLE_EN`: switch from A to B two cycles into the window → `invalid_pulse`, no `letter_valid`. Without the macro, the same stimulus → `letter_valid` with `letter_code` = 1.
